logic_alu_pipe: RTL and testbench

LOGIC_ALU_PIPE -- requirements
Module: logic_alu_pipe

---
 rtl/logic_alu_pkg.sv | 23 ++
 rtl/logic_alu_core.sv | 35 +++
 rtl/logic_alu_pipe.sv | 128 ++++++++++++
 tb/tb_logic_alu_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_alu_pkg.sv
// logic_alu_pkg -- shared definitions for the logic ALU pipeline.
//
// Contents:
//   op_e          3-bit bitwise operation code (OP_NAND .. OP_PASS)
//   DEF_WIDTH     default operand/result width
//   DEF_CNT_W     default transaction counter width
package logic_alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    OP_NAND = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/logic_alu_core.sv
// logic_alu_core -- purely combinational bitwise operation decoder.
//
// Ports:
//   a, b  [WIDTH-1:0]  operands (a is already the effective A)
//   op    op_e         operation select
//   y     [WIDTH-1:0]  result
module logic_alu_core
  import logic_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    y = '0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_alu_pipe.sv
// logic_alu_pipe -- single-stage valid/ready pipeline around logic_alu_core
// with an accumulator and a wrapping transfer counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b, in_op   operands and operation, sampled on input transfer
//   in_acc              take A from the accumulator and write the result back
//   acc_clr             clear the accumulator (an acc-mode write wins)
//   out_valid/out_ready output handshake
//   out_y               registered result
//   out_count           completed input transfers, wrapping
//   out_pop             popcount of out_y (only with LOGIC_ALU_PIPE_POPCOUNT_EN)
//
// Optional feature macro: LOGIC_ALU_PIPE_POPCOUNT_EN
module logic_alu_pipe
  import logic_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [2:0]                    in_op,
  input  logic                          in_acc,
  input  logic                          acc_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_y,
  output logic [CNT_W-1:0]              out_count
`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]    out_pop
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_eff, alu_y;
  logic             in_xfer, out_xfer;

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // A clear coincident with an acc-mode transfer computes with A = 0.
  assign a_eff = in_acc ? (acc_clr ? '0 : acc_q) : in_a;

  logic_alu_core #(.WIDTH(WIDTH)) u_core (
    .a  (a_eff),
    .b  (in_b),
    .op (op_e'(in_op)),
    .y  (alu_y)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    acc_d       = acc_q;
    count_d     = count_q;
    // A new load takes precedence, which keeps out_valid high when the
    // old result drains on the same edge.
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      count_d     = count_q + CNT_W'(1);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (in_xfer && in_acc) begin
      acc_d = alu_y;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_count = count_q;

`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
  localparam int POP_W = $clog2(WIDTH + 1);

  logic [POP_W-1:0] pop_q, pop_d, pop_sum;

  // Popcount of the value about to be loaded, so it lines up with out_y.
  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_sum = pop_sum + POP_W'(alu_y[i]);
    end
    pop_d = in_xfer ? pop_sum : pop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end

  assign out_pop = pop_q;
`endif

endmodule

// File: tb/tb_logic_alu_pipe.sv
// tb_logic_alu_pipe -- scoreboard bench for logic_alu_pipe (WIDTH=8, CNT_W=4).
// A posedge reference model pushes expected results; a negedge monitor
// pops and compares on every output transfer.
module tb_logic_alu_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int POP_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_acc = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_count;
`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
  logic [POP_W-1:0] out_pop;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] acc_m = '0;
  int               cnt_m = 0;
  logic             vld_m = 1'b0;

  always #5 clk = ~clk;

  logic_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_count (out_count)
`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
    ,
    .out_pop   (out_pop)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each op as a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [3:0] t;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: t = 4'b0111;
      3'd1: t = 4'b1000;
      3'd2: t = 4'b1110;
      3'd3: t = 4'b0001;
      3'd4: t = 4'b0110;
      3'd5: t = 4'b1001;
      3'd6: t = 4'b0011;
      default: t = 4'b1100;
    endcase
    for (int i = 0; i < WIDTH; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  // Reference model: evaluates the handshake rules at each rising edge.
  always @(posedge clk) begin
    logic xfer, oxfer;
    logic [WIDTH-1:0] a_eff, y;
    if (rst) begin
      exp_q.delete();
      acc_m = '0;
      cnt_m = 0;
      vld_m = 1'b0;
    end else begin
      oxfer = vld_m && out_ready;
      xfer  = in_valid && (!vld_m || out_ready);
      a_eff = in_acc ? (acc_clr ? '0 : acc_m) : in_a;
      y     = ref_op(in_op, a_eff, in_b);
      if (xfer) begin
        exp_q.push_back(y);
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
      end
      if (xfer && in_acc) acc_m = y;
      else if (acc_clr) acc_m = '0;
      vld_m = xfer ? 1'b1 : (oxfer ? 1'b0 : vld_m);
    end
  end

  // Monitor: compares DUT state against the model away from the edge.
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(vld_m));
    check("in_ready", 32'(in_ready), 32'(!vld_m || out_ready));
    check("out_count", 32'(out_count), 32'(cnt_m));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_y), 32'hDEAD_BEEF);
      end else begin
        check("out_y", 32'(out_y), 32'(exp_q[0]));
`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
        check("out_pop", 32'(out_pop), 32'($countones(exp_q[0])));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic acc, input logic clr);
    bit got = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; acc_clr = clr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_acc = 1'b0; acc_clr = 1'b0;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_chk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic acc, input logic clr, input logic [7:0] exp,
                          input string name);
    send(a, b, op, acc, clr);
    @(negedge clk);
    check(name, 32'(out_y), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp34 [8];
    exp34 = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    // Reset: in_valid is driven high during reset and must be discarded.
    in_valid = 1'b1; in_a = 8'h5A;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_y", 32'(out_y), 32'h0);
    check("rst_count", 32'(out_count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef LOGIC_ALU_PIPE_POPCOUNT_EN
    check("rst_pop", 32'(out_pop), 32'h0);
`endif
    @(posedge clk); #1;

    // All eight ops on fixed operands.
    for (int i = 0; i < 8; i++) send_chk(8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0, exp34[i], "op_table");
    check("count_after_ops", 32'(out_count), 32'd8);

    // Backpressure: result held, in_ready low, then load-on-consume.
    send(8'hAA, 8'h00, 3'b111, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h55; in_op = 3'b111;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'h0);
      check("stall_out_y", 32'(out_y), 32'hAA);
      check("stall_count", 32'(out_count), 32'd9);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_out_y", 32'(out_y), 32'h55);
    check("release_valid", 32'(out_valid), 32'h1);
    check("release_count", 32'(out_count), 32'd10);
    @(posedge clk); #1;

    // Accumulate, then clear coincident with an acc-mode write.
    clear_acc();
    send_chk(8'h00, 8'h01, 3'b010, 1'b1, 1'b0, 8'h01, "acc_or1");
    send_chk(8'h00, 8'h02, 3'b010, 1'b1, 1'b0, 8'h03, "acc_or2");
    send_chk(8'h00, 8'h04, 3'b010, 1'b1, 1'b0, 8'h07, "acc_or3");
    send_chk(8'hFF, 8'h10, 3'b010, 1'b1, 1'b1, 8'h10, "clr_write_wins");
    send_chk(8'h00, 8'h00, 3'b111, 1'b1, 1'b0, 8'h10, "acc_readback");
    clear_acc();
    send_chk(8'hFF, 8'h0F, 3'b100, 1'b1, 1'b0, 8'h0F, "acc_xor");
    send_chk(8'hF0, 8'h00, 3'b111, 1'b0, 1'b0, 8'hF0, "pop_f0");
    send_chk(8'hFF, 8'h00, 3'b111, 1'b0, 1'b0, 8'hFF, "pop_ff");
    send_chk(8'h00, 8'h00, 3'b111, 1'b0, 1'b0, 8'h00, "pop_00");

    // Counter wrap with CNT_W=4.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 17; i++) send(8'(i), 8'h3C, 3'(i), 1'b0, 1'b0);
    @(negedge clk);
    check("count_wrap", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    // Reset mid-stall, with a transfer coincident with reset.
    out_ready = 1'b0;
    send(8'h77, 8'h00, 3'b111, 1'b0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_stall_valid", 32'(out_valid), 32'h0);
    check("rst_stall_count", 32'(out_count), 32'h0);
    check("rst_stall_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Randomised traffic; the model and monitor do the checking.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      in_acc    = 1'($urandom);
      acc_clr   = ($urandom % 8) == 0;
      rst       = ($urandom % 64) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
